dvp_capture: RTL and testbench

//  Byte-to-pixel capture stage for the DVP camera path.

---
 rtl/dvp_capture.sv | 150 +++++++++++++++
 tb/tb_dvp_capture.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dvp_capture.sv
// DVP byte-to-pixel capture: packs byte pairs into 16-bit pixels, flags line/frame
// boundaries and checks geometry. Optional macro DVP_TEST_PATTERN_EN adds a tp_en port.
module dvp_capture #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int CW    = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frame_start,
  input  logic          href,
  input  logic [7:0]    din,
`ifdef DVP_TEST_PATTERN_EN
  input  logic          tp_en,
`endif
  output logic [15:0]   pix_data,
  output logic          pix_valid,
  output logic          sol,
  output logic          eof,
  output logic [CW-1:0] line_cnt,
  output logic          busy,
  output logic          frame_err
);

  localparam int DATA_W = 8;
  localparam logic [CW-1:0] PIX_FULL = CW'(IMG_W);
  localparam logic [CW-1:0] PIX_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] LINE_LAST = CW'(IMG_H - 1);

  typedef enum logic {S_IDLE, S_CAPTURE} state_t;

  state_t state_q, state_d;

  logic              phase_q;
  logic              href_d_q;
  logic              any_byte_q;
  logic              ovf_q;
  logic [CW-1:0]     pix_cnt_q;
  logic [CW-1:0]     line_cnt_q;
  logic [DATA_W-1:0] hi_p0;

  logic [15:0]       pix_data_p1;
  logic              vld_p1;
  logic              sol_p1;
  logic              eof_p1;
  logic              err_p1;

  logic capturing, take_byte, pix_done, last_pix, line_end, in_range, emit, abort;
  logic line_bad;
  logic [15:0] pix_word;

  // Pixel counter stops at IMG_W so overlong lines cannot wrap back into range.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == PIX_FULL) ? v : v + 1'b1;
  endfunction

  function automatic logic [15:0] pack_pix(input logic [DATA_W-1:0] hi,
                                           input logic [DATA_W-1:0] lo);
    return {hi, lo};
  endfunction

  assign capturing = (state_q == S_CAPTURE);
  assign take_byte = capturing && href;
  assign pix_done  = take_byte && phase_q;
  assign last_pix  = pix_done && (line_cnt_q == LINE_LAST) && (pix_cnt_q == PIX_LAST);
  assign line_end  = capturing && href_d_q && !href;
  assign in_range  = (pix_cnt_q != PIX_FULL);
  // A new frame start kills an in-flight pixel, except the frame's final one.
  assign emit      = pix_done && in_range && (!frame_start || last_pix);
  assign abort     = frame_start && capturing && any_byte_q && !last_pix;
  assign line_bad  = (pix_cnt_q != PIX_FULL) || phase_q || ovf_q;

`ifdef DVP_TEST_PATTERN_EN
  assign pix_word = tp_en ? {line_cnt_q[7:0], pix_cnt_q[7:0]} : pack_pix(hi_p0, din);
`else
  assign pix_word = pack_pix(hi_p0, din);
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (frame_start) state_d = S_CAPTURE;
      S_CAPTURE: begin
        if (frame_start)   state_d = S_CAPTURE;
        else if (last_pix) state_d = S_IDLE;
      end
      default:   state_d = S_IDLE;
    endcase
  end

  // Stage p0: high-byte holding register
  always_ff @(posedge clk) begin
    if (take_byte && !phase_q) hi_p0 <= din;
  end

  // Stage p1: registered pixel, flags and counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      phase_q     <= 1'b0;
      href_d_q    <= 1'b0;
      any_byte_q  <= 1'b0;
      ovf_q       <= 1'b0;
      pix_cnt_q   <= '0;
      line_cnt_q  <= '0;
      pix_data_p1 <= '0;
      vld_p1      <= 1'b0;
      sol_p1      <= 1'b0;
      eof_p1      <= 1'b0;
      err_p1      <= 1'b0;
    end else begin
      state_q  <= state_d;
      href_d_q <= frame_start ? 1'b0 : href;
      vld_p1   <= emit;
      sol_p1   <= emit && (pix_cnt_q == '0);
      eof_p1   <= emit && last_pix;
      err_p1   <= abort || (line_end && !frame_start && line_bad);
      if (emit) pix_data_p1 <= pix_word;

      if (frame_start) begin
        pix_cnt_q  <= '0;
        line_cnt_q <= '0;
        phase_q    <= 1'b0;
        any_byte_q <= 1'b0;
        ovf_q      <= 1'b0;
      end else if (line_end) begin
        line_cnt_q <= line_cnt_q + 1'b1;
        pix_cnt_q  <= '0;
        phase_q    <= 1'b0;
        ovf_q      <= 1'b0;
      end else if (take_byte) begin
        any_byte_q <= 1'b1;
        phase_q    <= ~phase_q;
        if (phase_q) begin
          pix_cnt_q <= sat_inc(pix_cnt_q);
          if (!in_range) ovf_q <= 1'b1;
        end
      end
    end
  end

  assign pix_data  = pix_data_p1;
  assign pix_valid = vld_p1;
  assign sol       = sol_p1;
  assign eof       = eof_p1;
  assign frame_err = err_p1;
  assign line_cnt  = line_cnt_q;
  assign busy      = (state_q == S_CAPTURE);

endmodule

// File: tb/tb_dvp_capture.sv
// Directed self-checking bench for dvp_capture with a 4x2 image.
module tb_dvp_capture;
  localparam int IMG_W = 4;
  localparam int IMG_H = 2;
  localparam int CW    = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          frame_start;
  logic          href;
  logic [7:0]    din;
`ifdef DVP_TEST_PATTERN_EN
  logic          tp_en;
`endif
  logic [15:0]   pix_data;
  logic          pix_valid;
  logic          sol;
  logic          eof;
  logic [CW-1:0] line_cnt;
  logic          busy;
  logic          frame_err;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  typedef struct packed {
    logic        sol;
    logic        eof;
    logic        busy;
    logic [15:0] d;
  } pix_t;

  pix_t q[$];
  int   err_seen = 0;

  dvp_capture #(.IMG_W(IMG_W), .IMG_H(IMG_H), .CW(CW)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .href(href), .din(din),
`ifdef DVP_TEST_PATTERN_EN
    .tp_en(tp_en),
`endif
    .pix_data(pix_data), .pix_valid(pix_valid), .sol(sol), .eof(eof),
    .line_cnt(line_cnt), .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pix_valid) q.push_back({sol, eof, busy, pix_data});
    if (frame_err) err_seen++;
  end

  task automatic cyc(input logic fs, input logic h, input logic [7:0] d);
    @(posedge clk);
    #1;
    frame_start = fs;
    href        = h;
    din         = d;
  endtask

  task automatic start_frame();
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
  endtask

  task automatic send_line(input int n, input logic [7:0] first);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, first + 8'(i));
    repeat (3) cyc(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_reset();
    rst = 1'b1; frame_start = 1'b0; href = 1'b0; din = 8'h00;
`ifdef DVP_TEST_PATTERN_EN
    tp_en = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    vec_cnt++; if (pix_data !== 16'h0) begin miss_cnt++; $display("FAIL reset_pix_data got %h want 0000", pix_data); end
    vec_cnt++; if (pix_valid !== 1'b0) begin miss_cnt++; $display("FAIL reset_pix_valid got %b want 0", pix_valid); end
    vec_cnt++; if (sol !== 1'b0) begin miss_cnt++; $display("FAIL reset_sol got %b want 0", sol); end
    vec_cnt++; if (eof !== 1'b0) begin miss_cnt++; $display("FAIL reset_eof got %b want 0", eof); end
    vec_cnt++; if (line_cnt !== '0) begin miss_cnt++; $display("FAIL reset_line_cnt got %0d want 0", line_cnt); end
    vec_cnt++; if (busy !== 1'b0) begin miss_cnt++; $display("FAIL reset_busy got %b want 0", busy); end
    vec_cnt++; if (frame_err !== 1'b0) begin miss_cnt++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
    rst = 1'b0;
    repeat (2) cyc(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_clean_frame();
    int b, e0;
    logic [15:0] exp_d;
    b = q.size(); e0 = err_seen;
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
    vec_cnt++; if (busy !== 1'b1) begin miss_cnt++; $display("FAIL clean_busy_start got %b want 1", busy); end
    send_line(8, 8'h01);
    vec_cnt++; if (line_cnt !== CW'(1)) begin miss_cnt++; $display("FAIL clean_line_cnt1 got %0d want 1", line_cnt); end
    send_line(8, 8'h01);
    vec_cnt++; if (q.size() - b !== 8) begin miss_cnt++; $display("FAIL clean_pix_count got %0d want 8", q.size() - b); end
    for (int i = 0; i < 8 && b + i < q.size(); i++) begin
      exp_d = {8'(2 * (i % 4) + 1), 8'(2 * (i % 4) + 2)};
      vec_cnt++; if (q[b+i].d !== exp_d) begin miss_cnt++; $display("FAIL clean_data[%0d] got %h want %h", i, q[b+i].d, exp_d); end
      vec_cnt++; if (q[b+i].sol !== (i % 4 == 0)) begin miss_cnt++; $display("FAIL clean_sol[%0d] got %b want %b", i, q[b+i].sol, (i % 4 == 0)); end
      vec_cnt++; if (q[b+i].eof !== (i == 7)) begin miss_cnt++; $display("FAIL clean_eof[%0d] got %b want %b", i, q[b+i].eof, (i == 7)); end
    end
    if (q.size() >= b + 8) begin
      vec_cnt++; if (q[b+7].busy !== 1'b0) begin miss_cnt++; $display("FAIL clean_busy_at_eof got %b want 0", q[b+7].busy); end
    end
    vec_cnt++; if (busy !== 1'b0) begin miss_cnt++; $display("FAIL clean_busy_end got %b want 0", busy); end
    vec_cnt++; if (line_cnt !== CW'(1)) begin miss_cnt++; $display("FAIL clean_line_cnt_hold got %0d want 1", line_cnt); end
    vec_cnt++; if (err_seen - e0 !== 0) begin miss_cnt++; $display("FAIL clean_no_err got %0d want 0", err_seen - e0); end
  endtask

  task automatic test_short_line();
    int b, e0;
    start_frame();
    b = q.size(); e0 = err_seen;
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 8'(i + 1));
    cyc(1'b0, 1'b0, 8'h00);
    @(posedge clk); @(negedge clk);
    vec_cnt++; if (frame_err !== 1'b1) begin miss_cnt++; $display("FAIL short_err_pulse got %b want 1", frame_err); end
    @(negedge clk);
    vec_cnt++; if (frame_err !== 1'b0) begin miss_cnt++; $display("FAIL short_err_single got %b want 0", frame_err); end
    repeat (2) cyc(1'b0, 1'b0, 8'h00);
    vec_cnt++; if (q.size() - b !== 3) begin miss_cnt++; $display("FAIL short_pix_count got %0d want 3", q.size() - b); end
    if (q.size() >= b + 3) begin
      vec_cnt++; if (q[b+2].d !== 16'h0506) begin miss_cnt++; $display("FAIL short_last_data got %h want 0506", q[b+2].d); end
    end
    vec_cnt++; if (err_seen - e0 !== 1) begin miss_cnt++; $display("FAIL short_err_count got %0d want 1", err_seen - e0); end
    vec_cnt++; if (line_cnt !== CW'(1)) begin miss_cnt++; $display("FAIL short_line_cnt got %0d want 1", line_cnt); end
  endtask

  task automatic test_odd_line();
    int b, e0;
    logic [15:0] exp_d;
    start_frame();
    b = q.size(); e0 = err_seen;
    send_line(7, 8'h01);
    vec_cnt++; if (q.size() - b !== 3) begin miss_cnt++; $display("FAIL odd_pix_count got %0d want 3", q.size() - b); end
    vec_cnt++; if (err_seen - e0 !== 1) begin miss_cnt++; $display("FAIL odd_err_count got %0d want 1", err_seen - e0); end
    b = q.size();
    send_line(8, 8'h11);
    vec_cnt++; if (q.size() - b !== 4) begin miss_cnt++; $display("FAIL odd_next_count got %0d want 4", q.size() - b); end
    for (int i = 0; i < 4 && b + i < q.size(); i++) begin
      exp_d = {8'(8'h11 + 2 * i), 8'(8'h12 + 2 * i)};
      vec_cnt++; if (q[b+i].d !== exp_d) begin miss_cnt++; $display("FAIL odd_next_data[%0d] got %h want %h", i, q[b+i].d, exp_d); end
      vec_cnt++; if (q[b+i].sol !== (i == 0)) begin miss_cnt++; $display("FAIL odd_next_sol[%0d] got %b want %b", i, q[b+i].sol, (i == 0)); end
      vec_cnt++; if (q[b+i].eof !== (i == 3)) begin miss_cnt++; $display("FAIL odd_next_eof[%0d] got %b want %b", i, q[b+i].eof, (i == 3)); end
    end
    vec_cnt++; if (err_seen - e0 !== 1) begin miss_cnt++; $display("FAIL odd_err_total got %0d want 1", err_seen - e0); end
  endtask

  task automatic test_long_line();
    int b, e0;
    start_frame();
    b = q.size(); e0 = err_seen;
    send_line(10, 8'h01);
    vec_cnt++; if (q.size() - b !== 4) begin miss_cnt++; $display("FAIL long_pix_count got %0d want 4", q.size() - b); end
    if (q.size() >= b + 4) begin
      vec_cnt++; if (q[b+3].d !== 16'h0708) begin miss_cnt++; $display("FAIL long_last_data got %h want 0708", q[b+3].d); end
    end
    vec_cnt++; if (err_seen - e0 !== 1) begin miss_cnt++; $display("FAIL long_err_count got %0d want 1", err_seen - e0); end
    vec_cnt++; if (line_cnt !== CW'(1)) begin miss_cnt++; $display("FAIL long_line_cnt got %0d want 1", line_cnt); end
  endtask

  task automatic test_abort();
    int b, e0;
    start_frame();
    e0 = err_seen;
    send_line(8, 8'h01);
    vec_cnt++; if (err_seen - e0 !== 0) begin miss_cnt++; $display("FAIL abort_line0_err got %0d want 0", err_seen - e0); end
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
    vec_cnt++; if (frame_err !== 1'b1) begin miss_cnt++; $display("FAIL abort_err_pulse got %b want 1", frame_err); end
    vec_cnt++; if (line_cnt !== CW'(0)) begin miss_cnt++; $display("FAIL abort_line_cnt got %0d want 0", line_cnt); end
    vec_cnt++; if (busy !== 1'b1) begin miss_cnt++; $display("FAIL abort_busy got %b want 1", busy); end
    cyc(1'b0, 1'b0, 8'h00);
    b = q.size();
    send_line(8, 8'h01);
    send_line(8, 8'h01);
    vec_cnt++; if (q.size() - b !== 8) begin miss_cnt++; $display("FAIL abort_next_count got %0d want 8", q.size() - b); end
    if (q.size() >= b + 8) begin
      vec_cnt++; if (q[b+7].eof !== 1'b1) begin miss_cnt++; $display("FAIL abort_next_eof got %b want 1", q[b+7].eof); end
    end
    vec_cnt++; if (err_seen - e0 !== 1) begin miss_cnt++; $display("FAIL abort_err_total got %0d want 1", err_seen - e0); end
  endtask

  task automatic test_back_to_back();
    int b, e0;
    start_frame();
    e0 = err_seen;
    send_line(8, 8'h01);
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 8'(i + 1));
    cyc(1'b1, 1'b1, 8'h08);
    cyc(1'b0, 1'b0, 8'h00);
    vec_cnt++; if (eof !== 1'b1) begin miss_cnt++; $display("FAIL b2b_eof got %b want 1", eof); end
    vec_cnt++; if (pix_data !== 16'h0708) begin miss_cnt++; $display("FAIL b2b_data got %h want 0708", pix_data); end
    vec_cnt++; if (busy !== 1'b1) begin miss_cnt++; $display("FAIL b2b_busy got %b want 1", busy); end
    repeat (2) cyc(1'b0, 1'b0, 8'h00);
    b = q.size();
    send_line(8, 8'h21);
    send_line(8, 8'h31);
    vec_cnt++; if (q.size() - b !== 8) begin miss_cnt++; $display("FAIL b2b_next_count got %0d want 8", q.size() - b); end
    if (q.size() >= b + 8) begin
      vec_cnt++; if (q[b].d !== 16'h2122) begin miss_cnt++; $display("FAIL b2b_next_first got %h want 2122", q[b].d); end
      vec_cnt++; if (q[b+7].d !== 16'h3738) begin miss_cnt++; $display("FAIL b2b_next_last got %h want 3738", q[b+7].d); end
      vec_cnt++; if (q[b+7].eof !== 1'b1) begin miss_cnt++; $display("FAIL b2b_next_eof got %b want 1", q[b+7].eof); end
    end
    vec_cnt++; if (err_seen - e0 !== 0) begin miss_cnt++; $display("FAIL b2b_err got %0d want 0", err_seen - e0); end
  endtask

  task automatic test_reset_midline();
    int b;
    logic [15:0] exp_d;
    start_frame();
    send_line(8, 8'h01);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 8'(i + 1));
    rst = 1'b1;
    #1;
    vec_cnt++; if (busy !== 1'b0) begin miss_cnt++; $display("FAIL rst_async_busy got %b want 0", busy); end
    vec_cnt++; if (line_cnt !== '0) begin miss_cnt++; $display("FAIL rst_async_line_cnt got %0d want 0", line_cnt); end
    vec_cnt++; if (pix_data !== 16'h0) begin miss_cnt++; $display("FAIL rst_async_pix_data got %h want 0000", pix_data); end
    vec_cnt++; if ({pix_valid, sol, eof, frame_err} !== 4'b0) begin miss_cnt++; $display("FAIL rst_async_flags got %b want 0000", {pix_valid, sol, eof, frame_err}); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    b = q.size();
    send_line(8, 8'h01);
    vec_cnt++; if (q.size() - b !== 0) begin miss_cnt++; $display("FAIL rst_idle_ignored got %0d want 0", q.size() - b); end
    vec_cnt++; if (busy !== 1'b0) begin miss_cnt++; $display("FAIL rst_idle_busy got %b want 0", busy); end
`ifdef DVP_TEST_PATTERN_EN
    tp_en = 1'b1;
`endif
    start_frame();
    b = q.size();
    send_line(8, 8'h41);
    send_line(8, 8'h41);
    vec_cnt++; if (q.size() - b !== 8) begin miss_cnt++; $display("FAIL rst_frame_count got %0d want 8", q.size() - b); end
    for (int i = 0; i < 8 && b + i < q.size(); i++) begin
`ifdef DVP_TEST_PATTERN_EN
      exp_d = {8'(i / 4), 8'(i % 4)};
`else
      exp_d = {8'(8'h41 + 2 * (i % 4)), 8'(8'h42 + 2 * (i % 4))};
`endif
      vec_cnt++; if (q[b+i].d !== exp_d) begin miss_cnt++; $display("FAIL rst_frame_data[%0d] got %h want %h", i, q[b+i].d, exp_d); end
    end
`ifdef DVP_TEST_PATTERN_EN
    tp_en = 1'b0;
`endif
  endtask

  initial begin
    test_reset();
    test_clean_frame();
    test_short_line();
    test_odd_line();
    test_long_line();
    test_abort();
    test_back_to_back();
    test_reset_midline();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
